// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
//   Store buffer between the MIPS core MEM stage and a slow data memory.
//   Stores are queued in an in-order FIFO and drained to memory with a
//   req/ack handshake in the background. Loads read memory combinationally,
//   with the youngest buffered store to the same word forwarded ahead of
//   memory data.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-low reset (0 = in reset)
//   memwrite      store strobe from the core
//   memaddr       core load/store byte address
//   memwritedata  core store data
//   memreaddata   load data returned to the core (forwarded or memory)
//   mem_req       write request to memory (high while draining head entry)
//   mem_addr      write address of the head entry
//   mem_wdata     write data of the head entry
//   mem_ack       memory accepted the current write
//   mem_raddr     read address to memory, always memaddr
//   mem_rdata     combinational memory read data
//   full/empty    FIFO occupancy flags
//   overflow      sticky flag: a store was dropped while full
//   count         number of valid entries
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [AW-1:0]            memaddr,
  input  logic [DW-1:0]            memwritedata,
  output logic [DW-1:0]            memreaddata,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ack,
  output logic [AW-1:0]            mem_raddr,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CW-1:0]    count_next;
  logic             pop;
  logic             do_push;
  logic             drop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign mem_req   = (state == REQ);
  assign mem_addr  = addr_q[head];
  assign mem_wdata = data_q[head];
  assign mem_raddr = memaddr;

  // A pop on the same edge frees the head slot, so a push into a full
  // buffer is still accepted when the head is being acknowledged.
  assign pop     = (state == REQ) && mem_ack;
  assign do_push = memwrite && (!full || pop);
  assign drop    = memwrite && full && !pop;

  always_comb begin
    count_next = count + CW'(do_push) - CW'(pop);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = REQ;
      REQ:     if (pop && count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state. When full with push and pop together, tail == head:
  // the clear of the popped slot is overridden by the set of the pushed one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      state    <= IDLE;
      overflow <= 1'b0;
      valid_q  <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (do_push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (drop) overflow <= 1'b1;
      count <= count_next;
      state <= state_next;
    end
  end

  // Entry payload needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[tail] <= memaddr;
      data_q[tail] <= memwritedata;
    end
  end

  // Walk entries oldest to youngest so the last match is the youngest store.
  always_comb begin
    logic [PW-1:0] idx;
    memreaddata = mem_rdata;
    idx         = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && (addr_q[idx][AW-1:2] == memaddr[AW-1:2]))
        memreaddata = data_q[idx];
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer
//   Directed bench for dmem_write_buffer with a write scoreboard: every
//   accepted store is queued and compared against the head presented on
//   the memory side when it is acknowledged.
//
// Ports: none (top-level bench).
module tb_dmem_write_buffer;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb[$];
  logic        model_req;
  logic        model_ovf;

  dmem_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the registered status against the model after an edge.
  task automatic check_status();
    check_output("count",    64'(count),    64'(sb.size()));
    check_output("empty",    64'(empty),    64'(sb.size() == 0));
    check_output("full",     64'(full),     64'(sb.size() == 4));
    check_output("overflow", 64'(overflow), 64'(model_ovf));
    check_output("mem_req",  64'(mem_req),  64'(model_req));
  endtask

  // One clock cycle: drive inputs at posedge+1, check the presented head,
  // update the scoreboard for the coming edge, then check status after it.
  task automatic apply_stimulus(input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic ack);
    logic popping;
    logic was_full;
    memwrite     = wr;
    memaddr      = a;
    memwritedata = d;
    mem_ack      = ack;
    #1;
    check_output("mem_req_pre", 64'(mem_req), 64'(model_req));
    if (model_req) begin
      check_output("mem_addr",  64'(mem_addr),  64'(sb[0][63:32]));
      check_output("mem_wdata", 64'(mem_wdata), 64'(sb[0][31:0]));
    end
    popping  = model_req && ack;
    was_full = (sb.size() == 4);
    if (popping) void'(sb.pop_front());
    if (wr) begin
      if (!was_full || popping) sb.push_back({a, d});
      else model_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    model_req = (sb.size() != 0);
    check_status();
    memwrite = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 12 && sb.size() != 0; i++)
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    check_output("drain_done_count", 64'(count), 64'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    sb.delete();
    model_req = 1'b0;
    model_ovf = 1'b0;
    @(negedge clk);
    check_status();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_status();
  endtask

  initial begin
    reset        = 1'b0;
    memwrite     = 1'b0;
    memaddr      = 32'h0;
    memwritedata = 32'h0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;
    model_req    = 1'b0;
    model_ovf    = 1'b0;

    // 1. Reset
    $display("[TB] reset check");
    reset_dut();
    mem_rdata = 32'h12345678;
    #1;
    check_output("rst_load", 64'(memreaddata), 64'h12345678);
    check_output("raddr", 64'(mem_raddr), 64'(memaddr));

    // 2. Single store drain with delayed ack
    $display("[TB] single store drain");
    apply_stimulus(1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    check_output("single_addr",  64'(mem_addr),  64'h40);
    check_output("single_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1);
    check_output("single_req_low", 64'(mem_req), 64'd0);

    // 3. Forwarding
    $display("[TB] forwarding");
    mem_rdata = 32'hCAFEF00D;
    apply_stimulus(1'b1, 32'h80, 32'h11111111, 1'b0);
    apply_stimulus(1'b1, 32'h80, 32'h22222222, 1'b0);
    memaddr = 32'h80; #1;
    check_output("fwd_80", 64'(memreaddata), 64'h22222222);
    memaddr = 32'h83; #1;
    check_output("fwd_83", 64'(memreaddata), 64'h22222222);
    memaddr = 32'h84; #1;
    check_output("fwd_84", 64'(memreaddata), 64'hCAFEF00D);
    memwrite = 1'b1; memwritedata = 32'h33333333; #1;
    check_output("fwd_same_cycle", 64'(memreaddata), 64'hCAFEF00D);
    memwrite = 1'b0;
    drain_all();

    // 4. Overflow and ordered drain
    $display("[TB] overflow");
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, 32'h100 + 32'(4 * i), 32'(i), 1'b0);
    apply_stimulus(1'b1, 32'h110, 32'h99, 1'b0);
    check_output("ovf_full",  64'(full),     64'd1);
    check_output("ovf_count", 64'(count),    64'd4);
    check_output("ovf_flag",  64'(overflow), 64'd1);
    drain_all();
    check_output("ovf_sticky", 64'(overflow), 64'd1);

    // 5. Full with simultaneous push and ack
    $display("[TB] full push with ack");
    reset_dut();
    for (int i = 1; i <= 4; i++)
      apply_stimulus(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0);
    apply_stimulus(1'b1, 32'h200, 32'hAA, 1'b1);
    check_output("fp_count",    64'(count),    64'd4);
    check_output("fp_overflow", 64'(overflow), 64'd0);
    check_output("fp_head",     64'(mem_wdata), 64'd2);
    drain_all();

    // 6. Reset in the middle of a drain
    $display("[TB] mid-operation reset");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
    mem_rdata = 32'h5A5A5A5A;
    memaddr   = 32'h504;
    reset     = 1'b0;
    #1;
    check_output("mr_req",      64'(mem_req),     64'd0);
    check_output("mr_count",    64'(count),       64'd0);
    check_output("mr_empty",    64'(empty),       64'd1);
    check_output("mr_overflow", 64'(overflow),    64'd0);
    check_output("mr_load",     64'(memreaddata), 64'h5A5A5A5A);
    reset_dut();
    memaddr = 32'h504; #1;
    check_output("mr_load_after", 64'(memreaddata), 64'h5A5A5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Sits directly downstream of the pipelined MIPS core's MEM stage, between the core's data-memory port (memwrite, memaddr, memwritedata, memreaddata) and a slow data memory with a req/ack write handshake.
- Stores retire into an in-order FIFO and drain to memory in the background, so the core never waits on store latency.
- Loads read memory combinationally. The youngest buffered store to the same word is forwarded ahead of memory data.

Parameters:
DEPTH, 4, number of buffered stores; power of 2, minimum 2
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 = in reset
memwrite  input  1  store strobe from the core MEM stage
memaddr  input  AW  core load/store byte address
memwritedata  input  DW  core store data
memreaddata  output  DW  load data returned to the core
mem_req  output  1  write request to data memory
mem_addr  output  AW  write address, head entry
mem_wdata  output  DW  write data, head entry
mem_ack  input  1  memory accepted the current write
mem_raddr  output  AW  read address to memory; always equals memaddr
mem_rdata  input  DW  memory read data, combinational
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a store was dropped
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (reset==0, asynchronous):
  - pointers and count cleared to 0, so empty=1 and full=0;
  - state forced to IDLE, so mem_req=0;
  - overflow=0; entry valid bits cleared.
  - Entry data contents are don't-care.
- FIFO:
  - Circular buffer with head and tail pointers of width $clog2(DEPTH); pointers wrap from DEPTH-1 to 0.
  - push = memwrite at the clock edge. The entry stores {memaddr, memwritedata}.
  - pop = (state==REQ) && mem_ack at the clock edge. mem_ack while mem_req==0 is ignored.
- Push/pop boundary cases:
  - push && pop: both occur and count is unchanged. This holds even when full; no overflow.
  - push && full && !pop: store dropped and overflow set to 1. overflow stays 1 until reset.
  - pop when empty cannot occur, because REQ is never entered with count 0.
- Drain FSM (2 states):
  - IDLE: mem_req=0. Goes to REQ at the next edge if count_next > 0. A push into an empty buffer therefore raises mem_req 1 cycle later.
  - REQ: mem_req=1.
    - mem_addr and mem_wdata show the head entry and are stable until the ack edge.
    - On ack: if count_next > 0, stay in REQ (back-to-back, next head presented the following cycle); otherwise go to IDLE.
- mem_addr and mem_wdata are don't-care in IDLE; drive the head entry anyway.
- Load forwarding (combinational):
  - Compare memaddr[AW-1:2] with the address of every valid entry.
  - memreaddata = data of the youngest matching entry (closest to tail); otherwise mem_rdata.
  - The entry being drained still counts as valid until its ack edge.
  - A store pushed in the same cycle as a load is not forwarded to that load.
- Byte offset bits [1:0] are ignored for matching; all stores are full-word.
- Reset mid-REQ: mem_req drops to 0 asynchronously and buffered stores are lost. The memory side must abandon any in-flight write.

Test Plan:
1. Reset check: hold reset=0, then release -> mem_req=0, empty=1, full=0, count=0, overflow=0; memreaddata follows mem_rdata (drive 0x12345678 -> 0x12345678).
2. Single store drain: push addr 0x40 / data 0xDEADBEEF, hold mem_ack=0 for 3 cycles, then 1 -> mem_req rises 1 cycle after push; mem_addr=0x40 and mem_wdata=0xDEADBEEF held stable; after the ack edge count=0 and mem_req=0.
3. Forwarding: push 0x80=0x11111111 then 0x80=0x22222222 with ack low, mem_rdata=0xCAFEF00D ->
   - load 0x80 returns 0x22222222;
   - load 0x83 returns 0x22222222;
   - load 0x84 returns 0xCAFEF00D.
4. Overflow: ack low, push 0x0/0x1/0x2/0x3 at addr 0x100/0x104/0x108/0x10C, then a 5th store -> full=1, count=4, overflow=1; draining with ack=1 yields exactly the 4 stores in order with mem_req continuous.
5. Full with simultaneous push and ack: with 4 entries, push 0xAA at 0x200 on the ack edge -> count stays 4, overflow=0, drain order is entries 2, 3, 4, then 0xAA.
6. Mid-operation reset: 3 entries, in REQ; assert reset between edges -> mem_req=0 before the next edge, count=0, overflow cleared, loads return mem_rdata.
